// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: data-bus bundle between the MEM-stage load/store unit
// and the data memory / bus fabric.
//   req    unit -> bus   request valid, held for the whole transaction
//   addr   unit -> bus   word-aligned address
//   we     unit -> bus   byte write enables (all zero for loads)
//   wdata  unit -> bus   byte-lane aligned store data
//   ack    bus  -> unit  one-cycle completion pulse
//   rdata  bus  -> unit  read word, valid together with ack
// Modports: master (load/store unit side), slave (memory side).
interface mem_access_unit_if;
    logic        req;
    logic [31:0] addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, addr, we, wdata, input ack, rdata);
    modport slave  (input req, addr, we, wdata, output ack, rdata);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit. Issues one req/ack data-bus
// transaction per load or store, stalls the pipeline until the transaction
// completes or times out, aligns store data/enables to byte lanes, extends
// load data, and holds the MEM-WB segment registers.
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   en, clear           MEM-WB register enable and synchronous flush
//   AluOutM..RdM        EX-MEM segment values of the instruction in MEM
//   dbus                data bus (mem_access_unit_if.master)
//   StallMem            combinational stall request to the hazard unit
//   AluOutW..BusErrW    MEM-WB segment register outputs
// Parameter MAX_WAIT: BUSY cycles without ack before the access aborts.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses skip
// the bus and complete immediately with BusErrW=1.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   clear,
    input  logic [31:0]            AluOutM,
    input  logic [31:0]            StoreDataM,
    input  logic [3:0]             MemWriteM,
    input  logic                   MemToRegM,
    input  logic [2:0]             RegWriteM,
    input  logic [4:0]             RdM,
    mem_access_unit_if.master      dbus,
    output logic                   StallMem,
    output logic [31:0]            AluOutW,
    output logic [31:0]            LoadDataW,
    output logic [4:0]             RdW,
    output logic [2:0]             RegWriteW,
    output logic                   MemToRegW,
    output logic                   BusErrW
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t      state, state_next;
    logic [7:0]  wait_cnt;
    logic        err_flag;
    logic [31:0] rdata_q;
    logic        access;
    logic [1:0]  offset;
    logic        trap;
    logic        issue, trap_go, timeout;
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic [31:0] ext_data, load_data;
    logic        resp_err;

    assign access   = MemToRegM | (|MemWriteM);
    assign offset   = AluOutM[1:0];
    assign resp_err = (state == RESP) && err_flag;

`ifdef MEM_MISALIGN_TRAP_EN
    logic is_half, is_word;
    always_comb begin
        is_half = (MemToRegM && (RegWriteM == 3'd2 || RegWriteM == 3'd5)) || (MemWriteM == 4'b0011);
        is_word = (MemToRegM && !(RegWriteM inside {3'd1, 3'd2, 3'd4, 3'd5})) || (MemWriteM == 4'b1111);
        trap    = access && ((is_half && offset[0]) || (is_word && offset != 2'b00));
    end
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // An ack in the same cycle as the final wait count wins over the timeout.
    always_comb begin
        state_next = state;
        StallMem   = 1'b0;
        issue      = 1'b0;
        trap_go    = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (access) begin
                    StallMem = 1'b1;
                    if (trap) begin
                        trap_go    = 1'b1;
                        state_next = RESP;
                    end else begin
                        issue      = 1'b1;
                        state_next = BUSY;
                    end
                end
            end
            BUSY: begin
                StallMem = 1'b1;
                if (dbus.ack) begin
                    state_next = RESP;
                end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    timeout    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bus fields are latched once at issue and held until the next issue;
    // the error flag lives only until the RESP cycle hands it to WB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbus.req   <= 1'b0;
            dbus.addr  <= '0;
            dbus.we    <= '0;
            dbus.wdata <= '0;
            wait_cnt   <= '0;
            err_flag   <= 1'b0;
            rdata_q    <= '0;
        end else if (issue) begin
            dbus.req   <= 1'b1;
            dbus.addr  <= {AluOutM[31:2], 2'b00};
            dbus.we    <= MemToRegM ? 4'b0000 : (MemWriteM << offset);
            dbus.wdata <= StoreDataM << {offset, 3'b000};
            wait_cnt   <= '0;
            err_flag   <= 1'b0;
        end else if (trap_go) begin
            err_flag <= 1'b1;
            rdata_q  <= '0;
        end else if (state == BUSY) begin
            if (dbus.ack) begin
                dbus.req <= 1'b0;
                rdata_q  <= dbus.rdata;
            end else if (timeout) begin
                dbus.req <= 1'b0;
                err_flag <= 1'b1;
                rdata_q  <= '0;
            end else begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end else if (state == RESP) begin
            err_flag <= 1'b0;
        end
    end

    // Misaligned halves fall back to the half selected by offset[1].
    always_comb begin
        sel_byte = 8'(rdata_q >> {offset, 3'b000});
        sel_half = offset[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (RegWriteM)
            3'd1:    ext_data = {{24{sel_byte[7]}}, sel_byte};
            3'd2:    ext_data = {{16{sel_half[15]}}, sel_half};
            3'd4:    ext_data = {24'd0, sel_byte};
            3'd5:    ext_data = {16'd0, sel_half};
            default: ext_data = rdata_q;
        endcase
        load_data = MemToRegM ? ext_data : 32'd0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            AluOutW   <= '0;
            LoadDataW <= '0;
            RdW       <= '0;
            RegWriteW <= '0;
            MemToRegW <= 1'b0;
            BusErrW   <= 1'b0;
        end else if (en && !StallMem) begin
            if (clear) begin
                AluOutW   <= '0;
                LoadDataW <= '0;
                RdW       <= '0;
                RegWriteW <= '0;
                MemToRegW <= 1'b0;
                BusErrW   <= 1'b0;
            end else begin
                AluOutW   <= AluOutM;
                LoadDataW <= load_data;
                RdW       <= RdM;
                RegWriteW <= resp_err ? 3'd0 : RegWriteM;
                MemToRegW <= MemToRegM;
                BusErrW   <= resp_err;
            end
        end
    end

endmodule
